// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and WIDTH legality bounds.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell, purely combinational; the only arithmetic in the serial adder.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per clock through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_adder: WIDTH out of range 2..32");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder_1bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Sequencer: LSB-first shifting; sum/cout only move at the completion edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        psum  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= {fa_s, psum[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= {fa_s, psum[WIDTH-1:1]};
                        cout  <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry register holds the carry into the MSB during the last shift
                        ovf   <= carry ^ fa_c;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against a plain-arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
    endtask

    task automatic launch(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc);
        a     = oa;
        b     = ob;
        cin   = oc;
        start = 1'b1;
    endtask

    // Runs one operation from its accepting edge to the return to IDLE.
    task automatic follow(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                          input bit noise, input bit keep);
        int          total;
        int          sa;
        int          sb;
        logic [W:0]  r;
        total = int'(oa) + int'(ob) + int'(oc);
        r     = (W+1)'(total);
        sa    = oa[W-1] ? int'(oa) - 256 : int'(oa);
        sb    = ob[W-1] ? int'(ob) - 256 : int'(ob);
        tick();
        if (!keep) start = 1'b0;
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_done", 32'(done), 32'd0);
        check_outputs("acc_hold");
        for (int i = 1; i < int'(W); i++) begin
            if (noise && i == 2) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                cin   = 1'($urandom);
            end
            if (noise && i == 4 && !keep) start = 1'b0;
            tick();
            check("shift_busy", 32'(busy), 32'd1);
            check("shift_done", 32'(done), 32'd0);
            check_outputs("shift_hold");
        end
        tick();
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
        exp_ovf  = ((sa + sb + int'(oc)) > 127 || (sa + sb + int'(oc)) < -128) ? 1'b1 : 1'b0;
        check("cmpl_done", 32'(done), 32'd1);
        check("cmpl_busy", 32'(busy), 32'd1);
        check_outputs("cmpl");
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check_outputs("idle_hold");
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_outputs("rst");
        rst = 1'b0;
        tick();
        check("idle_nostart_busy", 32'(busy), 32'd0);

        launch(8'hFF, 8'h01, 1'b0); follow(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        launch(8'h03, 8'h05, 1'b1); follow(8'h03, 8'h05, 1'b1, 1'b0, 1'b0);
        launch(8'hA5, 8'h5A, 1'b1); follow(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);

        // start and operand changes mid-operation must be ignored
        launch(8'h01, 8'h01, 1'b0); follow(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        check("noise_no_restart", 32'(busy), 32'd0);

        // reset at shift 4 aborts and clears everything
        launch(8'h0F, 8'h01, 1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        #1;
        exp_sum  = '0;
        exp_cout = 1'b0;
        exp_ovf  = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_outputs("abort");
        launch(8'h0F, 8'h01, 1'b0);
        tick();
        check("abort_hold_done", 32'(done), 32'd0);
        check("abort_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        follow(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

        // start held high: accepted every W+2 cycles
        ra = 8'h12; rb = 8'h34; rc = 1'b0;
        launch(ra, rb, rc);
        for (int n = 0; n < 4; n++) begin
            follow(ra, rb, rc, 1'b0, 1'b1);
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            if (n < 3) launch(ra, rb, rc);
        end
        start = 1'b0;
        tick();
        check("b2b_end_busy", 32'(busy), 32'd0);

`ifdef SERIAL_ADDER_OVF_EN
        launch(8'h7F, 8'h01, 1'b0); follow(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        check("ovf_pos", 32'(ovf), 32'd1);
        launch(8'hFF, 8'h01, 1'b0); follow(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        check("ovf_wrap", 32'(ovf), 32'd0);
        check("ovf_wrap_cout", 32'(cout), 32'd1);
        launch(8'h80, 8'h80, 1'b0); follow(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            launch(ra, rb, rc);
            follow(ra, rb, rc, 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
